// File: rtl/dm_mem_ctrl.sv
// dm_mem_ctrl: data-memory responder for the DAG address path.
// Stalls the sequencer while it performs one wait-stated SRAM access.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   ps_dm_en      access request (sampled only when idle)
//   ps_dm_wrt     1 = write, 0 = read
//   dg_dm_add     word address
//   bc_dt_out     write data
//   dm_bc_dt      registered read data (holds last read)
//   dm_bc_dt_vld  one-cycle pulse when dm_bc_dt is updated by a read
//   dm_ps_stall   sequencer hold while an access is in flight
//   dm_ps_err     one-cycle pulse when the latched address is out of range
module dm_mem_ctrl #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 16,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ps_dm_en,
    input  logic          ps_dm_wrt,
    input  logic [AW-1:0] dg_dm_add,
    input  logic [DW-1:0] bc_dt_out,
    output logic [DW-1:0] dm_bc_dt,
    output logic          dm_bc_dt_vld,
    output logic          dm_ps_stall,
    output logic          dm_ps_err
);

    localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [2:0]  WAIT_INI = 3'(WAIT_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [AW-1:0]   r_addr;
    logic            r_wrt;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_vld;
    logic            r_err;

    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_inr;
    logic [IW-1:0]   w_idx;

    // Full-width compare: upper address bits must not alias into the array.
    assign w_inr = ({1'b0, r_addr} < DEPTH_W);
    assign w_idx = r_addr[IW-1:0];

    assign dm_bc_dt     = r_rdata;
    assign dm_bc_dt_vld = r_vld;
    assign dm_ps_err    = r_err;
    assign dm_ps_stall  = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wrt   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (ps_dm_en) begin
                        r_addr  <= dg_dm_add;
                        r_wrt   <= ps_dm_wrt;
                        r_wdata <= bc_dt_out;
                        r_cnt   <= WAIT_INI;
                        r_state <= (WAIT_CYC == 0) ? S_ACC : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    // <= 1 also recovers from a corrupted zero count
                    if (r_cnt <= 3'd1) begin
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_state <= S_IDLE;
                    r_err   <= ~w_inr;
                    if (!r_wrt) begin
                        r_vld   <= 1'b1;
                        r_rdata <= w_inr ? r_mem[w_idx] : '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Array is never reset; an async reset forces IDLE, which drops
    // any pending commit.
    always_ff @(posedge clk) begin
        if (r_state == S_ACC && r_wrt && w_inr) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_dm_mem_ctrl.sv
// tb_dm_mem_ctrl: scoreboard bench for dm_mem_ctrl.
// Drives accesses, queues expected responses, monitor compares.
module tb_dm_mem_ctrl;

    localparam int W     = 1;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps_dm_en = 1'b0;
    logic        ps_dm_wrt = 1'b0;
    logic [15:0] dg_dm_add = '0;
    logic [15:0] bc_dt_out = '0;
    logic [15:0] dm_bc_dt;
    logic        dm_bc_dt_vld;
    logic        dm_ps_stall;
    logic        dm_ps_err;

    logic        en0 = 1'b0;
    logic        wrt0 = 1'b0;
    logic [15:0] add0 = '0;
    logic [15:0] dat0 = '0;
    logic [15:0] dt0;
    logic        vld0;
    logic        stall0;
    logic        err0;

    always #5 clk = ~clk;

    dm_mem_ctrl #(
        .DW(16), .AW(16), .DEPTH(DEPTH), .WAIT_CYC(W)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .ps_dm_en(ps_dm_en),
        .ps_dm_wrt(ps_dm_wrt),
        .dg_dm_add(dg_dm_add),
        .bc_dt_out(bc_dt_out),
        .dm_bc_dt(dm_bc_dt),
        .dm_bc_dt_vld(dm_bc_dt_vld),
        .dm_ps_stall(dm_ps_stall),
        .dm_ps_err(dm_ps_err)
    );

    dm_mem_ctrl #(
        .DW(16), .AW(16), .DEPTH(DEPTH), .WAIT_CYC(0)
    ) u_dut0 (
        .clk(clk),
        .rst_n(rst_n),
        .ps_dm_en(en0),
        .ps_dm_wrt(wrt0),
        .dg_dm_add(add0),
        .bc_dt_out(dat0),
        .dm_bc_dt(dt0),
        .dm_bc_dt_vld(vld0),
        .dm_ps_stall(stall0),
        .dm_ps_err(err0)
    );

    typedef struct {
        int          cyc;
        bit          vld;
        bit          err;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    bit          busy[int];
    logic [15:0] mdl[int];
    int          cyc = 0;
    int          next_free = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    // Called on a negedge; returns on the negedge after acceptance.
    task automatic issue(input bit wrt, input logic [15:0] addr,
                         input logic [15:0] data, input bit hold);
        int   acc;
        exp_t e;
        bit   oor;
        ps_dm_en  = 1'b1;
        ps_dm_wrt = wrt;
        dg_dm_add = addr;
        bc_dt_out = data;
        acc = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        for (int c = acc; c <= acc + W; c++) busy[c] = 1'b1;
        next_free = acc + W + 2;
        oor = (int'(addr) >= DEPTH);
        e.cyc  = acc + W + 1;
        e.vld  = !wrt;
        e.err  = oor;
        e.data = '0;
        if (wrt) begin
            if (!oor) mdl[int'(addr)] = data;
            else q.push_back(e);
        end else begin
            if (!oor) e.data = mdl[int'(addr)];
            q.push_back(e);
        end
        while (cyc < acc) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        if (!hold) begin
            ps_dm_en  = 1'b0;
            ps_dm_wrt = 1'($urandom);
            dg_dm_add = 16'($urandom);
            bc_dt_out = 16'($urandom);
        end
    endtask

    // Monitor: stall against the busy map, pulses against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                chk("stall", 32'(dm_ps_stall), 32'(busy.exists(cyc)));
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_resp: got none expected at cyc %0d",
                             q[0].cyc);
                    void'(q.pop_front());
                end
                if (dm_bc_dt_vld || dm_ps_err) begin
                    if (q.size() == 0 || q[0].cyc != cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got vld=%0b err=%0b required none (cyc %0d)",
                                 dm_bc_dt_vld, dm_ps_err, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("vld", 32'(dm_bc_dt_vld), 32'(e.vld));
                        chk("err", 32'(dm_ps_err), 32'(e.err));
                        if (e.vld) chk("rdata", 32'(dm_bc_dt), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        int          acc;
        logic [15:0] a;
        bit          h;

        repeat (3) @(negedge clk);
        chk("rst_dt", 32'(dm_bc_dt), 0);
        chk("rst_vld", 32'(dm_bc_dt_vld), 0);
        chk("rst_stall", 32'(dm_ps_stall), 0);
        chk("rst_err", 32'(dm_ps_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 16'h0000, 16'h0000, 1'b0);
        issue(1'b1, 16'h0005, 16'h0000, 1'b0);
        issue(1'b1, 16'h0020, 16'hBEEF, 1'b0);
        issue(1'b1, 16'h0030, 16'h1357, 1'b0);

        issue(1'b1, 16'h0010, 16'hA5C3, 1'b0);
        issue(1'b0, 16'h0010, 16'h0000, 1'b0);

        issue(1'b1, 16'h0001, 16'h1111, 1'b1);
        issue(1'b0, 16'h0001, 16'h0000, 1'b0);

        issue(1'b1, 16'h0400, 16'hFFFF, 1'b0);
        issue(1'b0, 16'h0400, 16'h0000, 1'b0);
        issue(1'b0, 16'h0000, 16'h0000, 1'b0);

        issue(1'b0, 16'h0020, 16'h0000, 1'b0);
        dg_dm_add = 16'h0030;
        issue(1'b0, 16'h0030, 16'h0000, 1'b0);

        repeat (W + 4) @(negedge clk);
        ps_dm_en  = 1'b1;
        ps_dm_wrt = 1'b1;
        dg_dm_add = 16'h0005;
        bc_dt_out = 16'h1234;
        acc = cyc + 1;
        for (int c = acc; c <= acc + W; c++) busy[c] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        ps_dm_en = 1'b0;
        rst_n = 1'b0;
        busy.delete();
        #1;
        chk("midrst_dt", 32'(dm_bc_dt), 0);
        chk("midrst_vld", 32'(dm_bc_dt_vld), 0);
        chk("midrst_stall", 32'(dm_ps_stall), 0);
        chk("midrst_err", 32'(dm_ps_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        next_free = 0;
        @(negedge clk);
        issue(1'b0, 16'h0005, 16'h0000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 16'h0040 + 16'(i), 16'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = 16'(DEPTH + $urandom_range(0, 65535 - DEPTH));
            else
                a = 16'h0040 + 16'($urandom_range(0, 15));
            h = (i < 39) ? 1'($urandom) : 1'b0;
            issue(1'($urandom), a, 16'($urandom), h);
        end
        repeat (W + 4) @(negedge clk);

        en0  = 1'b1;
        wrt0 = 1'b1;
        add0 = 16'h0002;
        dat0 = 16'h6B2D;
        @(posedge clk);
        #1;
        chk("w0_stall_acc", 32'(stall0), 1);
        @(negedge clk);
        en0 = 1'b0;
        @(posedge clk);
        #1;
        chk("w0_stall_end", 32'(stall0), 0);
        chk("w0_err", 32'(err0), 0);
        @(negedge clk);
        en0  = 1'b1;
        wrt0 = 1'b0;
        @(posedge clk);
        #1;
        chk("r0_stall_acc", 32'(stall0), 1);
        chk("r0_vld_early", 32'(vld0), 0);
        @(negedge clk);
        en0  = 1'b0;
        add0 = 16'h0030;
        @(posedge clk);
        #1;
        chk("r0_vld", 32'(vld0), 1);
        chk("r0_data", 32'(dt0), 32'h6B2D);
        chk("r0_stall_end", 32'(stall0), 0);
        @(posedge clk);
        #1;
        chk("r0_vld_pulse", 32'(vld0), 0);

        repeat (8) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
